// File: rtl/fp_pkg.sv
// Shared constants and pipeline-stage types for the normalize/round block.
// Single-precision layout only: 8-bit exponent, 24-bit significand with hidden bit.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 24;
  localparam int GRS_W   = 3;
  localparam int LZC_W   = 5;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  typedef enum logic [1:0] {
    K_NORM    = 2'd0,
    K_ZERO    = 2'd1,
    K_UNDER   = 2'd2,
    K_SPECIAL = 2'd3
  } kind_t;

  typedef struct packed {
    logic              sign;
    kind_t             kind;
    logic [EXP_W:0]    exp;
    logic [MAN_W-1:0]  mant;
    logic [GRS_W-1:0]  grs;
  } s1_t;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
  } s2_t;

  function automatic logic [31:0] pack_fp(input logic sign,
                                          input logic [EXP_W-1:0] exp,
                                          input logic [MAN_W-2:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized 24-bit significand with guard/round/sticky.
// Purely combinational; the caller handles renormalization on carry-out.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] mant,
  input  logic [GRS_W-1:0] grs,
  output logic [MAN_W-1:0] rounded,
  output logic             carry,
  output logic             inexact
);

  logic             inc;
  logic [MAN_W:0]   sum;

  // Ties break toward an even lsb.
  assign inc     = grs[2] & (grs[1] | grs[0] | mant[0]);
  assign sum     = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
  assign rounded = sum[MAN_W-1:0];
  assign carry   = sum[MAN_W];
  assign inexact = |grs;

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize-then-round pipeline producing packed IEEE-754 singles.
// Stage 1 normalizes and classifies; stage 2 rounds, detects overflow and packs.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_carry,
  input  logic [MAN_W-1:0] in_mant,
  input  logic [2:0]       in_grs,
  input  logic [4:0]       in_lzc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_advance;
  s1_t         s1;
  s1_t         s1_next;
  s2_t         s2;
  s2_t         s2_next;
  logic [26:0] shifted;

  logic [23:0] rnd_mant;
  logic        rnd_carry;
  logic        rnd_inexact;
  logic [8:0]  fin_exp;
  logic [22:0] fin_frac;
  logic        unused_bits;

  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = ~s1_valid | s1_advance;
  assign out_valid  = s2_valid;
  assign out_result = s2.result;
  assign out_flags  = s2.flags;

  // Stage 1: classify the operand and normalize the significand.
  always_comb begin
    s1_next      = '0;
    shifted      = {in_mant, in_grs} << in_lzc;
    s1_next.sign = in_sign;
    if (in_exp == 8'hFF) begin
      s1_next.kind = K_SPECIAL;
      s1_next.exp  = 9'd255;
      s1_next.mant = in_mant;
    end else if (in_carry) begin
      s1_next.kind = K_NORM;
      s1_next.exp  = {1'b0, in_exp} + 9'd1;
      s1_next.mant = {1'b1, in_mant[23:1]};
      s1_next.grs  = {in_mant[0], in_grs[2], in_grs[1] | in_grs[0]};
    end else if (in_mant == 24'd0) begin
      s1_next.kind = K_ZERO;
    end else if ({3'b000, in_lzc} >= in_exp) begin
      s1_next.kind = K_UNDER;
    end else begin
      s1_next.kind = K_NORM;
      s1_next.exp  = {1'b0, in_exp} - {4'b0000, in_lzc};
      s1_next.mant = shifted[26:3];
      s1_next.grs  = shifted[2:0];
    end
  end

  // Stage 1 register: loads whenever the slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1 <= s1_next;
      end
    end
  end

  fp_round_rne u_round (
    .mant    (s1.mant),
    .grs     (s1.grs),
    .rounded (rnd_mant),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  // Only the hidden bit of the rounded significand is implied by the exponent.
  assign unused_bits = rnd_mant[23];

  // Stage 2: renormalize a rounding carry, detect overflow, pack the result.
  always_comb begin
    s2_next = '0;
    if (rnd_carry) begin
      fin_exp  = s1.exp + 9'd1;
      fin_frac = 23'd0;
    end else begin
      fin_exp  = s1.exp;
      fin_frac = rnd_mant[22:0];
    end
    case (s1.kind)
      K_SPECIAL: begin
        s2_next.result = pack_fp(s1.sign, 8'hFF, s1.mant[22:0]);
      end
      K_ZERO: begin
        s2_next.result = pack_fp(s1.sign, 8'h00, 23'd0);
      end
      K_UNDER: begin
        s2_next.result          = pack_fp(s1.sign, 8'h00, 23'd0);
        s2_next.flags[FLAG_UNF] = 1'b1;
        s2_next.flags[FLAG_INX] = 1'b1;
      end
      K_NORM: begin
        if (fin_exp >= 9'(EXP_MAX)) begin
          s2_next.result          = pack_fp(s1.sign, 8'hFF, 23'd0);
          s2_next.flags[FLAG_OVF] = 1'b1;
          s2_next.flags[FLAG_INX] = 1'b1;
        end else begin
          s2_next.result          = pack_fp(s1.sign, fin_exp[7:0], fin_frac);
          s2_next.flags[FLAG_INX] = rnd_inexact;
        end
      end
      default: begin
        s2_next = '0;
      end
    endcase
  end

  // Stage 2 register doubles as the output register; it freezes while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2 <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed self-checking bench for fp_norm_round: latency, rounding/special
// cases streamed at full rate, backpressure ordering, and mid-flight reset.
module tb_fp_norm_round;

  typedef struct packed {
    logic        sign;
    logic        carry;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [2:0]  grs;
    logic [4:0]  lzc;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_carry;
  logic [23:0] in_mant;
  logic [2:0]  in_grs;
  logic [4:0]  in_lzc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  fp_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_carry   (in_carry),
    .in_mant    (in_mant),
    .in_grs     (in_grs),
    .in_lzc     (in_lzc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input vec_t v);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_carry = v.carry;
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_grs   = v.grs;
    in_lzc   = v.lzc;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, v.res);
    check({tag, "_flags"}, {29'd0, out_flags}, {29'd0, v.flags});
  endtask

  initial begin
    //            sign  carry exp    mant       grs   lzc    result        flags
    vecs[0]  = '{1'b0, 1'b1, 8'h7F, 24'h000000, 3'b000, 5'd0,  32'h40000000, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 8'h80, 24'h100000, 3'b000, 5'd3,  32'h3E800000, 3'b000};
    vecs[2]  = '{1'b0, 1'b0, 8'h7F, 24'hFFFFFF, 3'b100, 5'd0,  32'h40000000, 3'b001};
    vecs[3]  = '{1'b0, 1'b1, 8'hFE, 24'h800000, 3'b000, 5'd0,  32'h7F800000, 3'b101};
    vecs[4]  = '{1'b0, 1'b0, 8'h10, 24'h000001, 3'b000, 5'd23, 32'h00000000, 3'b011};
    vecs[5]  = '{1'b0, 1'b1, 8'h7F, 24'h800000, 3'b000, 5'd0,  32'h40400000, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 8'h50, 24'h000000, 3'b000, 5'd24, 32'h80000000, 3'b000};
    vecs[7]  = '{1'b0, 1'b0, 8'hFF, 24'h400001, 3'b000, 5'd0,  32'h7FC00001, 3'b000};
    vecs[8]  = '{1'b0, 1'b0, 8'h7F, 24'h800000, 3'b100, 5'd0,  32'h3F800000, 3'b001};
    vecs[9]  = '{1'b1, 1'b0, 8'h7F, 24'h800000, 3'b110, 5'd0,  32'hBF800001, 3'b001};
    vecs[10] = '{1'b0, 1'b1, 8'h7F, 24'h000001, 3'b000, 5'd0,  32'h40000000, 3'b001};
    vecs[11] = '{1'b0, 1'b0, 8'hFE, 24'hFFFFFF, 3'b110, 5'd0,  32'h7F800000, 3'b101};
    vecs[12] = '{1'b0, 1'b0, 8'h0F, 24'h000100, 3'b000, 5'd15, 32'h00000000, 3'b011};
    vecs[13] = '{1'b0, 1'b0, 8'h10, 24'h000100, 3'b000, 5'd15, 32'h00800000, 3'b000};
    vecs[14] = '{1'b0, 1'b0, 8'h85, 24'h020000, 3'b101, 5'd6,  32'h3F800028, 3'b000};
    vecs[15] = '{1'b1, 1'b1, 8'h81, 24'h000003, 3'b011, 5'd0,  32'hC1000002, 3'b001};

    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_sign = 1'b0; in_carry = 1'b0;
    in_exp = 8'd0; in_mant = 24'd0; in_grs = 3'd0; in_lzc = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {29'd0, out_flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Two-cycle latency on an isolated transfer
    send(vecs[0]);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_not_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_out("lat", vecs[0]);
    @(negedge clk);
    check("lat_single_beat", {31'd0, out_valid}, 32'd0);

    // Full-rate stream of every directed vector
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        check_out($sformatf("vec%0d", i - 2), vecs[i - 2]);
      end
      check($sformatf("stream_in_ready%0d", i), {31'd0, in_ready}, 32'd1);
      if (i < NV) begin
        send(vecs[i]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back inputs, out_ready low for four cycles
    out_ready = 1'b0;
    send(vecs[0]);
    @(negedge clk);
    check("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    send(vecs[1]);
    @(negedge clk);
    check("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
    check_out("bp_a_held", vecs[0]);
    send(vecs[8]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("bp_stall_ready%0d", k), {31'd0, in_ready}, 32'd0);
      check_out($sformatf("bp_stall%0d", k), vecs[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_b", vecs[1]);
    @(negedge clk);
    check_out("bp_c", vecs[8]);
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with two entries in flight
    out_ready = 1'b0;
    send(vecs[2]);
    @(negedge clk);
    send(vecs[9]);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    check("mid_rst_flags", {29'd0, out_flags}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mid_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
      check($sformatf("mid_in_ready%0d", k), {31'd0, in_ready}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
